// File: rtl/panel_pkg.sv
// Shared constants and quadrature decode helper
// for the Tiny32 front-panel input block.
package panel_pkg;

  localparam int EV_CW   = 0;
  localparam int EV_CCW  = 1;
  localparam int EV_BTN  = 2;
  localparam int EV_QERR = 3;

  localparam int BTN_CON = 2;
  localparam int BTN_PSH = 1;
  localparam int BTN_BAK = 0;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_CW,
    STEP_CCW,
    STEP_ERR
  } step_e;

  // Classify an {A,B} transition
  function automatic step_e quad_step(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    step_e s;
    unique case ({prev, cur})
      4'b0001, 4'b0111,
      4'b1110, 4'b1000: s = STEP_CW;
      4'b0100, 4'b1101,
      4'b1011, 4'b0010: s = STEP_CCW;
      4'b0011, 4'b1100,
      4'b0110, 4'b1001: s = STEP_ERR;
      default:          s = STEP_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/debounce.sv
// Single-button debouncer: input level must hold
// for 2^DEBOUNCE_BITS clocks before the output follows.
module debounce
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  logic                     state_q, state_d;
  logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
  logic                     out_q;

  // Count while input disagrees; toggle at terminal count
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (in != state_q) begin
      if (&cnt_q) begin
        state_d = ~state_q;
      end else begin
        cnt_d = cnt_q + DEBOUNCE_BITS'(1);
      end
    end
  end

  // Level/counter registers; output is the inverted level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= 1'b1;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= ~state_q;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/panel_input.sv
// Front-panel conditioner: button debounce, quadrature
// position counter, sticky event flags and level irq.
module panel_input
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 16,
  parameter int COUNT_BITS    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  con_button,
  input  logic                  psh_button,
  input  logic                  bak_button,
  input  logic                  tra,
  input  logic                  trb,
  input  logic                  irq_ack,
  input  logic                  clr_count,
  output logic [2:0]            buttons,
  output logic [COUNT_BITS-1:0] count,
  output logic [3:0]            events,
  output logic                  irq
);

  logic [2:0] btn_s1_q, btn_s2_q;
  logic [1:0] enc_s1_q, enc_s2_q;
  logic [2:0] btn_w;
  logic [2:0] btn_prev_q;

  logic [1:0]            prev_q, prev_d;
  logic                  valid_q, valid_d;
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic [COUNT_BITS-1:0] base;
  logic [3:0]            events_q, events_d;
  logic [3:0]            ev_set;
  step_e                 step;

  // Button synchronisers idle at released (high)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1_q <= 3'b111;
      btn_s2_q <= 3'b111;
    end else begin
      btn_s1_q <= {con_button, psh_button, bak_button};
      btn_s2_q <= btn_s1_q;
    end
  end

  // Encoder synchronisers track pins even in reset,
  // so the valid reload sees the true phase
  always_ff @(posedge clk) begin
    enc_s1_q <= {tra, trb};
    enc_s2_q <= enc_s1_q;
  end

  for (genvar i = 0; i < 3; i++) begin : g_db
    debounce #(
      .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .in   (btn_s2_q[i]),
      .out  (btn_w[i])
    );
  end

  // Decode step, update count and sticky flags
  always_comb begin
    prev_d  = enc_s2_q;
    valid_d = 1'b1;
    ev_set  = '0;
    step    = quad_step(prev_q, enc_s2_q);
    base    = clr_count ? '0 : count_q;
    count_d = base;
    if (valid_q) begin
      unique case (step)
        STEP_CW: begin
          count_d        = base + COUNT_BITS'(1);
          ev_set[EV_CW]  = 1'b1;
        end
        STEP_CCW: begin
          count_d        = base - COUNT_BITS'(1);
          ev_set[EV_CCW] = 1'b1;
        end
        STEP_ERR: ev_set[EV_QERR] = 1'b1;
        default: ;
      endcase
    end
    ev_set[EV_BTN] = |(btn_w & ~btn_prev_q);
    events_d = (irq_ack ? 4'b0000 : events_q) | ev_set;
  end

  // Encoder, counter and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q     <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      events_q   <= '0;
      btn_prev_q <= '0;
    end else begin
      prev_q     <= prev_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      events_q   <= events_d;
      btn_prev_q <= btn_w;
    end
  end

  assign buttons = btn_w;
  assign count   = count_q;
  assign events  = events_q;
  assign irq     = |events_q;

endmodule

// File: tb/tb_panel_input.sv
// Directed bench for panel_input with a short
// debounce window and an 8-bit position counter.
module tb_panel_input;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       con_button = 1'b1;
  logic       psh_button = 1'b1;
  logic       bak_button = 1'b1;
  logic       tra = 1'b1;
  logic       trb = 1'b1;
  logic       irq_ack = 1'b0;
  logic       clr_count = 1'b0;
  logic [2:0] buttons;
  logic [7:0] count;
  logic [3:0] events;
  logic       irq;
  logic [1:0] ab = 2'b11;

  int errors = 0;
  int checks = 0;

  panel_input #(
    .DEBOUNCE_BITS(4),
    .COUNT_BITS   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .con_button(con_button),
    .psh_button(psh_button),
    .bak_button(bak_button),
    .tra       (tra),
    .trb       (trb),
    .irq_ack   (irq_ack),
    .clr_count (clr_count),
    .buttons   (buttons),
    .count     (count),
    .events    (events),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] cw_next(
    input logic [1:0] s
  );
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] ccw_next(
    input logic [1:0] s
  );
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic drive_ab(input logic [1:0] v);
    @(negedge clk);
    tra = v[1];
    trb = v[0];
    ab  = v;
  endtask

  task automatic step_cw();
    drive_ab(cw_next(ab));
  endtask

  task automatic step_ccw();
    drive_ab(ccw_next(ab));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic ack,
                       input logic clr);
    @(negedge clk);
    irq_ack   = ack;
    clr_count = clr;
    @(negedge clk);
    irq_ack   = 1'b0;
    clr_count = 1'b0;
  endtask

  initial begin
    // reset and idle
    tick(3);
    check("rst_count", count, 8'h00);
    check("rst_events", events, 4'b0000);
    check("rst_irq", irq, 1'b0);
    check("rst_buttons", buttons, 3'b000);
    @(negedge clk) reset = 1'b0;
    tick(20);
    check("idle_count", count, 8'h00);
    check("idle_events", events, 4'b0000);

    // glitch shorter than the window
    @(negedge clk) psh_button = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) psh_button = 1'b1;
    tick(30);
    check("glitch_buttons", buttons, 3'b000);
    check("glitch_events", events, 4'b0000);

    // real press: 2 + 16 + 1 clocks
    @(negedge clk) psh_button = 1'b0;
    tick(18);
    check("press_18", buttons, 3'b000);
    tick(1);
    check("press_19", buttons, 3'b010);
    tick(1);
    check("press_event", events, 4'b0100);
    check("press_irq", irq, 1'b1);
    tick(5);
    @(negedge clk) psh_button = 1'b1;
    tick(25);
    check("release_buttons", buttons, 3'b000);
    check("release_events", events, 4'b0100);
    pulse(1'b1, 1'b0);
    tick(1);
    check("ack_btn", events, 4'b0000);

    // four CW cycles
    for (int i = 0; i < 16; i++) begin
      step_cw();
      tick(10);
    end
    check("cw16_count", count, 8'h10);
    check("cw16_events", events, 4'b0001);
    check("cw16_irq", irq, 1'b1);

    // seventeen CCW edges
    for (int i = 0; i < 17; i++) begin
      step_ccw();
      tick(10);
    end
    check("ccw17_count", count, 8'hFF);
    check("ccw17_events", events, 4'b0011);

    // back-to-back steps up to 127, then wrap
    pulse(1'b1, 1'b1);
    tick(1);
    check("clr_count", count, 8'h00);
    check("clr_events", events, 4'b0000);
    for (int i = 0; i < 127; i++) begin
      step_cw();
    end
    tick(3);
    check("b2b_127", count, 8'h7F);
    step_cw();
    tick(3);
    check("wrap_80", count, 8'h80);

    // both phases toggle together
    drive_ab(ab ^ 2'b11);
    tick(3);
    check("qerr_count", count, 8'h80);
    check("qerr_events", events, 4'b1001);

    // ack on the same clock as a CW step
    step_cw();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) irq_ack = 1'b1;
    tick(1);
    check("race_events", events, 4'b0001);
    check("race_count", count, 8'h81);
    @(negedge clk) irq_ack = 1'b0;
    pulse(1'b1, 1'b0);
    tick(1);
    check("ack_events", events, 4'b0000);
    check("ack_irq", irq, 1'b0);

    // clr_count on the same clock as a CCW step
    pulse(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step_cw();
    end
    tick(3);
    check("five", count, 8'h05);
    step_ccw();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) clr_count = 1'b1;
    tick(1);
    check("clr_race_count", count, 8'hFF);
    check("clr_race_events", events, 4'b0011);
    @(negedge clk) clr_count = 1'b0;

    // reset mid-operation, no step on re-arm
    step_ccw();
    @(negedge clk) reset = 1'b1;
    tick(3);
    check("mid_rst_count", count, 8'h00);
    check("mid_rst_events", events, 4'b0000);
    @(negedge clk) reset = 1'b0;
    tick(10);
    check("rearm_count", count, 8'h00);
    check("rearm_events", events, 4'b0000);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
